add_vec_gen: RTL and testbench
==============================

# add_vec_gen

Synthesizable test-vector generator for the 4-bit adder `add`. It produces packed 16-bit golden words in the same format the adder bench reads from `teste.txt`, and computes each expected sum and carry internally. Words stream out over a valid/ready handshake to an on-chip checker, a UART dumper, or a vector RAM writer. This block is the producer end of the vector format; the bench is the consumer.

## Interface
- `NUM_TESTS`, default 24: number of words emitted per run; legal range 1..256.
- `SEED`, default 8'hA5: LFSR start value; must be nonzero. Only used when `ADD_VEC_LFSR_EN` is defined.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run; ignored while `busy`=1.
- `mode`  in  1  0 = sequential sweep, 1 = LFSR; sampled on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse after the last handshake.
- `vec_valid`  out  1  `vec_data` holds a word.
- `vec_ready`  in  1  consumer accepts the word; a transfer happens when `vec_valid` and `vec_ready` are both 1.
- `vec_data`  out  16  packed word: [15:13]=0, [12:9]=num2, [8:5]=num1, [4:1]=sum[3:0], [0]=carry.
- `vec_idx`  out  8  index of the current word, 0..NUM_TESTS-1.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on `start`. The index and LFSR are loaded on this transition.
  - RUN → DONE on the handshake with `vec_idx`=NUM_TESTS-1.
  - DONE → IDLE unconditionally after one cycle; `done`=1 only in DONE.
- Sweep mode: num1 = idx[3:0], num2 = idx[7:4].
- LFSR mode:
  - 8-bit Fibonacci LFSR, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - num1 = lfsr[3:0], num2 = lfsr[7:4].
  - Reloaded with `SEED` on start; advances only on a handshake.
- Golden arithmetic: {carry, sum} = {1'b0,num1} + {1'b0,num2}, 5-bit result with no truncation before the split.
- `vec_valid`=1 throughout RUN.
- `vec_data` and `vec_idx` hold stable while `vec_valid`=1 and `vec_ready`=0. They change only on a handshake.
- `vec_idx` increments on each handshake and does not wrap: the run ends at NUM_TESTS-1. With NUM_TESTS=256, the 8-bit index reaches 255 and the FSM stops there.
- `start` in RUN or DONE is dropped; it is not queued.
- `vec_ready` high while idle has no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `vec_valid`=0, `vec_data`=16'h0000, `vec_idx`=0. The FSM goes to IDLE and the LFSR loads `SEED`.
- Reset mid-run: the cycle after `rst` is sampled high, all outputs take their reset values. No `done` is produced and the partial run is abandoned.
- Latency:
  - `start` sampled at edge k → `vec_valid`=1, `busy`=1, `vec_idx`=0 after edge k.
  - Throughput is one word per cycle while `vec_ready`=1.
- Last handshake at edge m → `done`=1 and `vec_valid`=0 after edge m; `busy`=0 after edge m+1.
- `start` is first accepted again in the IDLE cycle following DONE.
- `vec_data` is registered; there is no combinational path from `vec_ready` to `vec_data`. The only combinational dependency on `vec_ready` is the next-state logic.

## Configuration
- Macro `ADD_VEC_LFSR_EN`.
- Defined: the LFSR sub-module is instantiated and `mode`=1 selects pseudo-random operands.
- Undefined: there is no LFSR logic, `mode` is ignored (treated as 0), only sweep mode exists, and `SEED` is unused.

## Structure
- Package `add_vec_pkg` holds:
  - the state typedef (IDLE/RUN/DONE);
  - `VEC_W`=16 and `OPND_W`=4;
  - field-position constants (NUM2_LSB=9, NUM1_LSB=5, SUM_LSB=1, CARRY_BIT=0);
  - `MODE_SWEEP` and `MODE_LFSR`.
- Sub-module `add_vec_lfsr` has `clk`, `rst`, `load`, `step` and `q[7:0]`, plus parameter `SEED`. It is compiled only under `ADD_VEC_LFSR_EN`.

## Test plan
- Sweep, NUM_TESTS=24, `vec_ready` tied 1:
  - words 0, 1, 16 = 16'h0000, 16'h0022, 16'h0202;
  - exactly 24 handshakes;
  - `done` on the cycle after the handshake with `vec_idx`=23.
- Sweep, NUM_TESTS=256: the last word (idx 255: 15+15) = 16'h1FFD, carry=1; `vec_idx` does not wrap before `done`.
- Backpressure: `vec_ready` toggles 1,0,0,1 repeating → `vec_data` and `vec_idx` are stable during the 0 cycles; no word is skipped or repeated.
- `start` pulsed during RUN and during DONE → ignored; a single `done` is produced; a later `start` in IDLE restarts at idx 0.
- `rst` asserted at idx 5 → outputs are at reset values the next cycle; no `done`; a new `start` begins at idx 0 with word 16'h0000.
- `ADD_VEC_LFSR_EN` defined, `mode`=1, SEED=8'hA5 → word 0 = 16'h14BE (5+10=15, carry 0); LFSR next = 8'h4A, so word 1 has num1=10, num2=4, sum=14.

Source files
------------

// File: rtl/add_vec_pkg.sv
// Shared types and constants for the add_vec_gen test-vector generator:
// FSM states, packed-word field positions and the golden-word builder.
package add_vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_W     = 16;
  localparam int OPND_W    = 4;
  localparam int NUM2_LSB  = 9;
  localparam int NUM1_LSB  = 5;
  localparam int SUM_LSB   = 1;
  localparam int CARRY_BIT = 0;

  localparam logic MODE_SWEEP = 1'b0;
  localparam logic MODE_LFSR  = 1'b1;

  // Carry comes from the 5-bit sum, so nothing is truncated before the split.
  function automatic logic [VEC_W-1:0] make_word(input logic [OPND_W-1:0] num1,
                                                 input logic [OPND_W-1:0] num2);
    logic [OPND_W:0]  total;
    logic [VEC_W-1:0] w;
    total = {1'b0, num1} + {1'b0, num2};
    w = '0;
    w[NUM2_LSB +: OPND_W] = num2;
    w[NUM1_LSB +: OPND_W] = num1;
    w[SUM_LSB +: OPND_W]  = total[OPND_W-1:0];
    w[CARRY_BIT]          = total[OPND_W];
    return w;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/add_vec_lfsr.sv
// 8-bit Fibonacci LFSR operand source; only present when ADD_VEC_LFSR_EN is defined.
// Reloads SEED on reset or load, advances only on step.
`ifdef ADD_VEC_LFSR_EN
module add_vec_lfsr
  import add_vec_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`endif

// File: rtl/add_vec_gen.sv
// Golden test-vector producer for the 4-bit adder, streaming packed words over valid/ready.
// Optional pseudo-random operand mode is built in when ADD_VEC_LFSR_EN is defined.
module add_vec_gen
  import add_vec_pkg::*;
#(
  parameter int         NUM_TESTS = 24,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [VEC_W-1:0] vec_data,
  output logic [7:0]       vec_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_TESTS - 1);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [VEC_W-1:0] data_q, data_d;
  logic [7:0]       idx_q, idx_d;
  logic             mode_q, mode_d;

  logic             mode_eff;
  logic [VEC_W-1:0] seed_word;
  logic [VEC_W-1:0] step_word;
  logic             handshake;
  logic [7:0]       idx_inc;

  assign handshake = valid_q & vec_ready;
  assign idx_inc   = idx_q + 8'd1;

`ifdef ADD_VEC_LFSR_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_step_val;

  add_vec_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load ((state_q == IDLE) & start),
    .step ((state_q == RUN) & handshake),
    .q    (lfsr_q)
  );

  // The word after a handshake must come from the value the LFSR is stepping to.
  assign lfsr_step_val = lfsr_next(lfsr_q);
  assign mode_eff      = mode;
  assign seed_word     = make_word(SEED[3:0], SEED[7:4]);
  assign step_word     = make_word(lfsr_step_val[3:0], lfsr_step_val[7:4]);
`else
  logic [8:0] unused_cfg;
  assign unused_cfg = {mode, SEED};
  assign mode_eff   = MODE_SWEEP;
  assign seed_word  = '0;
  assign step_word  = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 8'd0;
          mode_d  = mode_eff;
          data_d  = (mode_eff == MODE_LFSR) ? seed_word : make_word(4'd0, 4'd0);
        end
      end
      RUN: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_inc;
            data_d = (mode_q == MODE_LFSR) ? step_word
                                           : make_word(idx_inc[3:0], idx_inc[7:4]);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= 8'd0;
      mode_q  <= MODE_SWEEP;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_valid = valid_q;
  assign vec_data  = data_q;
  assign vec_idx   = idx_q;

endmodule

// File: tb/tb_add_vec_gen.sv
// Self-checking bench for add_vec_gen: two instances (24 and 256 words), randomized
// ready patterns, checked against an arithmetic reference of the vector format.
module tb_add_vec_gen;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic ready = 1'b0;
  logic sel   = 1'b0;

  logic        a_busy, a_done, a_valid, b_busy, b_done, b_valid;
  logic [15:0] a_data, b_data;
  logic [7:0]  a_idx, b_idx;

  logic        vbusy, vdone, vvalid;
  logic [15:0] vdata;
  logic [7:0]  vidx;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_vec_gen #(.NUM_TESTS(24), .SEED(8'hA5)) dut24 (
    .clk       (clk),
    .rst       (rst),
    .start     (start & ~sel),
    .mode      (mode),
    .busy      (a_busy),
    .done      (a_done),
    .vec_valid (a_valid),
    .vec_ready (ready & ~sel),
    .vec_data  (a_data),
    .vec_idx   (a_idx)
  );

  add_vec_gen #(.NUM_TESTS(256), .SEED(8'hA5)) dut256 (
    .clk       (clk),
    .rst       (rst),
    .start     (start & sel),
    .mode      (mode),
    .busy      (b_busy),
    .done      (b_done),
    .vec_valid (b_valid),
    .vec_ready (ready & sel),
    .vec_data  (b_data),
    .vec_idx   (b_idx)
  );

  assign vbusy  = sel ? b_busy  : a_busy;
  assign vdone  = sel ? b_done  : a_done;
  assign vvalid = sel ? b_valid : a_valid;
  assign vdata  = sel ? b_data  : a_data;
  assign vidx   = sel ? b_idx   : a_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference word from the vector format: num2 | num1 | sum[3:0] | carry.
  function automatic logic [15:0] ref_word(input int a, input int b);
    int s;
    s = a + b;
    return 16'((b * 512) + (a * 32) + ((s % 16) * 2) + (s / 16));
  endfunction

  function automatic int ref_lfsr(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x * 2) % 256) + fb;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(vbusy),  32'd0);
    check({tag, "_done"},  32'(vdone),  32'd0);
    check({tag, "_valid"}, 32'(vvalid), 32'd0);
    check({tag, "_data"},  32'(vdata),  32'h0);
    check({tag, "_idx"},   32'(vidx),   32'd0);
  endtask

  // pat: 0 ready tied high, 1 ready 1,0,0,1 repeating, 2 random.
  // inj: pulse start once during RUN and once during DONE.
  // abort_at: assert rst when this index is presented (-1 = never).
  task automatic run(input int n, input int pat, input bit mode_in, input bit inj,
                     input int abort_at);
    int  idx;
    int  x;
    int  cyc;
    bit  fin;
    bit  r;
    bit  lf;
    logic [15:0] exp;
    idx = 0;
    x   = 8'hA5;
    cyc = 0;
    fin = 1'b0;
`ifdef ADD_VEC_LFSR_EN
    lf = mode_in;
`else
    lf = 1'b0;
`endif
    mode  = mode_in;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
    check("start_busy",  32'(vbusy),  32'd1);
    check("start_valid", 32'(vvalid), 32'd1);
    while (!fin && cyc < 4 * n + 20) begin
      if (vvalid) begin
        exp = lf ? ref_word(x % 16, x / 16) : ref_word(idx % 16, idx / 16);
        check("idx",  32'(vidx),  32'(idx));
        check("data", 32'(vdata), 32'(exp));
        if (idx == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          ready = 1'b0;
          check_reset_outputs("abort");
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(vdone), 32'd0);
          end
          return;
        end
        case (pat)
          0:       r = 1'b1;
          1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        ready = r;
        if (inj && cyc == 2) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (r) begin
          idx++;
          x = ref_lfsr(x);
        end
      end else begin
        check("end_done",   32'(vdone), 32'd1);
        check("end_busy",   32'(vbusy), 32'd1);
        check("handshakes", 32'(idx),   32'(n));
        if (inj) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        check("post_done", 32'(vdone),  32'd0);
        check("post_busy", 32'(vbusy),  32'd0);
        @(negedge clk);
        check("idle_valid", 32'(vvalid), 32'd0);
        check("idle_done",  32'(vdone),  32'd0);
        fin = 1'b1;
      end
      cyc++;
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    $display("run n=%0d pat=%0d mode=%0d inj=%0d: %0d words seen", n, pat, mode_in, inj, idx);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_valid", 32'(vvalid), 32'd0);
    check("idle_ready_busy",  32'(vbusy),  32'd0);
    ready = 1'b0;

    run(24, 0, 1'b0, 1'b0, -1);
    run(24, 1, 1'b0, 1'b0, -1);
    run(24, 2, 1'b0, 1'b1, -1);
    run(24, 0, 1'b0, 1'b0, 5);
    run(24, 2, 1'b0, 1'b0, -1);
`ifndef ADD_VEC_LFSR_EN
    run(24, 2, 1'b1, 1'b0, -1);
`endif

    sel = 1'b1;
    @(negedge clk);
    run(256, 0, 1'b0, 1'b0, -1);
    run(256, 2, 1'b0, 1'b0, -1);
    sel = 1'b0;
    @(negedge clk);

`ifdef ADD_VEC_LFSR_EN
    run(24, 0, 1'b1, 1'b0, -1);
    run(24, 2, 1'b1, 1'b1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
